// File: rtl/sig_change_logger.sv
// Change recorder: samples a signal bundle every clock and queues a time-stamped
// {ts, prev, curr} record in a first-word fall-through FIFO for a valid/ready consumer.
module sig_change_logger #(
  parameter int WIDTH = 6,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           sig_i,
  input  logic                       clr_i,
  input  logic                       ev_ready_i,
  output logic                       ev_valid_o,
  output logic [TS_W-1:0]            ev_ts_o,
  output logic [WIDTH-1:0]           ev_prev_o,
  output logic [WIDTH-1:0]           ev_curr_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [7:0]                 drop_cnt_o,
  output logic                       overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] curr;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             head;
  logic [TS_W-1:0]  ts;
  logic             armed;
  logic [WIDTH-1:0] prev;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic [7:0]       drop_cnt;
  logic             overflow;

  logic change;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    change = armed && (sig_i != prev);
    full   = (count == LVL_W'(DEPTH));
    pop    = (count != '0) && ev_ready_i;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    push   = change && (!full || pop);
    drop   = change && full && !pop;
  end

  // NOTE: non-blocking assignments everywhere in clocked logic so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts       <= '0;
      armed    <= 1'b0;
      prev     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      ts    <= ts + 1'b1;
      armed <= 1'b1;
      prev  <= sig_i;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (clr_i) begin
        drop_cnt <= {7'd0, drop};
        overflow <= drop;
      end else if (drop) begin
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        overflow <= 1'b1;
      end
    end
  end

  // NOTE: the record storage is deliberately not reset; count gates every read,
  // so stale entries are never visible and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ts: ts, prev: prev, curr: sig_i};
  end

  always_comb begin
    head       = mem[rd_ptr];
    ev_valid_o = (count != '0);
    ev_ts_o    = ev_valid_o ? head.ts   : '0;
    ev_prev_o  = ev_valid_o ? head.prev : '0;
    ev_curr_o  = ev_valid_o ? head.curr : '0;
    level_o    = count;
    drop_cnt_o = drop_cnt;
    overflow_o = overflow;
  end

endmodule

// File: tb/tb_sig_change_logger.sv
// Self-checking bench for sig_change_logger: queue-based reference model compared
// every cycle, plus directed checks of the documented scenarios.
module tb_sig_change_logger;

  localparam int WIDTH = 6;
  localparam int TS_W  = 16;
  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int VEC_W = 1 + LVL_W + TS_W + 2*WIDTH + 8 + 1;

  typedef struct {
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] curr;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] sig = '0;
  logic             clr = 1'b0;
  logic             ready = 1'b0;
  logic             ev_valid;
  logic [TS_W-1:0]  ev_ts;
  logic [WIDTH-1:0] ev_prev;
  logic [WIDTH-1:0] ev_curr;
  logic [LVL_W-1:0] level;
  logic [7:0]       drop_cnt;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  rec_t             q[$];
  logic [TS_W-1:0]  m_ts = '0;
  logic             m_armed = 1'b0;
  logic [WIDTH-1:0] m_prev = '0;
  int               m_drop = 0;
  logic             m_ovf = 1'b0;

  sig_change_logger #(.WIDTH(WIDTH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_i      (sig),
    .clr_i      (clr),
    .ev_ready_i (ready),
    .ev_valid_o (ev_valid),
    .ev_ts_o    (ev_ts),
    .ev_prev_o  (ev_prev),
    .ev_curr_o  (ev_curr),
    .level_o    (level),
    .drop_cnt_o (drop_cnt),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  wire [VEC_W-1:0] obs_vec = {ev_valid, level, ev_ts, ev_prev, ev_curr, drop_cnt, overflow};

  function automatic logic [VEC_W-1:0] exp_vec();
    logic [TS_W-1:0]  t = '0;
    logic [WIDTH-1:0] p = '0;
    logic [WIDTH-1:0] c = '0;
    if (q.size() != 0) begin
      t = q[0].ts; p = q[0].prev; c = q[0].curr;
    end
    return {q.size() != 0, LVL_W'(q.size()), t, p, c, 8'(m_drop), m_ovf};
  endfunction

  // Advance the model by the rules for one edge using the current inputs, then clock the DUT.
  task automatic step();
    bit pop, chg, drp;
    if (!rst_n) begin
      q.delete();
      m_ts = '0; m_armed = 1'b0; m_prev = '0; m_drop = 0; m_ovf = 1'b0;
    end else begin
      drp = 1'b0;
      if (m_armed) begin
        chg = (sig !== m_prev);
        pop = (q.size() != 0) && ready;
        if (chg && q.size() == DEPTH && !pop) drp = 1'b1;
        if (pop) void'(q.pop_front());
        if (chg && !drp) q.push_back('{ts: m_ts, prev: m_prev, curr: sig});
      end
      m_prev  = sig;
      m_armed = 1'b1;
      m_ts    = m_ts + 1'b1;
      if (clr) begin
        m_drop = drp ? 1 : 0;
        m_ovf  = drp;
      end else if (drp) begin
        if (m_drop != 255) m_drop++;
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] hold_sig);
    rst_n = 1'b0; sig = hold_sig; clr = 1'b0; ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(6'h15);
    checks++;
    if (obs_vec !== '0) begin
      errors++; $display("FAIL reset_values: got %h expected 0", obs_vec);
    end
    step(); // arm edge with sig != 0
    checks++;
    if (ev_valid !== 1'b0 || level !== '0) begin
      errors++; $display("FAIL arm_no_record: valid=%b level=%0d expected 0/0", ev_valid, level);
    end
    do_reset(6'h00);
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec() || ev_valid !== 1'b0) begin
        errors++; $display("FAIL idle_hold cyc %0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_ordered_records();
    do_reset(6'h00);
    ready = 1'b1;
    while (m_ts != 16'd10) step();
    sig = 6'h01;
    step();
    checks++;
    if ({ev_valid, ev_ts, ev_prev, ev_curr} !== {1'b1, 16'd10, 6'h00, 6'h01}) begin
      errors++; $display("FAIL first_record: got v=%b ts=%0d prev=%h curr=%h expected 1/10/00/01",
                         ev_valid, ev_ts, ev_prev, ev_curr);
    end
    while (m_ts != 16'd30) begin
      step();
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL order_gap: got %h expected %h", obs_vec, exp_vec());
      end
    end
    sig = 6'h21;
    step();
    checks++;
    if ({ev_valid, level, ev_ts, ev_prev, ev_curr} !== {1'b1, 4'd1, 16'd30, 6'h01, 6'h21}) begin
      errors++; $display("FAIL second_record: got v=%b lvl=%0d ts=%0d prev=%h curr=%h expected 1/1/30/01/21",
                         ev_valid, level, ev_ts, ev_prev, ev_curr);
    end
  endtask

  task automatic test_multi_bit();
    do_reset(6'h00);
    ready = 1'b0;
    step(); step();
    sig = 6'h21;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if ({level, ev_prev, ev_curr} !== {4'd1, 6'h00, 6'h21} || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL multi_bit: got lvl=%0d prev=%h curr=%h expected 1/00/21",
                         level, ev_prev, ev_curr);
    end
  endtask

  task automatic test_overflow();
    logic [TS_W-1:0] first_ts;
    do_reset(6'h00);
    ready = 1'b0;
    step();
    first_ts = m_ts;
    for (int i = 0; i < 10; i++) begin
      sig = 6'(i + 1);
      step();
    end
    checks++;
    if ({level, drop_cnt, overflow, ev_ts, ev_prev, ev_curr} !==
        {4'd8, 8'd2, 1'b1, first_ts, 6'h00, 6'h01}) begin
      errors++; $display("FAIL overflow_fill: got lvl=%0d drop=%0d ovf=%b ts=%0d prev=%h curr=%h expected 8/2/1/%0d/00/01",
                         level, drop_cnt, overflow, ev_ts, ev_prev, ev_curr, first_ts);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec() || ev_ts !== first_ts) begin
        errors++; $display("FAIL stall_stable cyc %0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
    clr = 1'b1; sig = 6'h30; // drop on the clear edge
    step();
    checks++;
    if ({drop_cnt, overflow} !== {8'd1, 1'b1}) begin
      errors++; $display("FAIL clr_with_drop: got drop=%0d ovf=%b expected 1/1", drop_cnt, overflow);
    end
    step();
    clr = 1'b0;
    checks++;
    if ({drop_cnt, overflow, level} !== {8'd0, 1'b0, 4'd8}) begin
      errors++; $display("FAIL clr: got drop=%0d ovf=%b lvl=%0d expected 0/0/8", drop_cnt, overflow, level);
    end
    ready = 1'b1; sig = 6'h31;
    step();
    ready = 1'b0;
    checks++;
    if ({level, drop_cnt, overflow} !== {4'd8, 8'd0, 1'b0} || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL full_push_pop: got lvl=%0d drop=%0d ovf=%b expected 8/0/0",
                         level, drop_cnt, overflow);
    end
  endtask

  task automatic test_saturate();
    ready = 1'b0;
    for (int i = 0; i < 270; i++) begin
      sig = sig ^ 6'h01;
      step();
    end
    checks++;
    if ({drop_cnt, overflow} !== {8'd255, 1'b1} || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL saturate: got drop=%0d ovf=%b expected 255/1", drop_cnt, overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(6'h00);
    ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      sig = 6'(i + 8);
      step();
    end
    checks++;
    if (level !== 4'd5) begin
      errors++; $display("FAIL mid_fill: got lvl=%0d expected 5", level);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (obs_vec !== '0) begin
      errors++; $display("FAIL mid_reset: got %h expected 0", obs_vec);
    end
    for (int i = 0; i < 4; i++) step(); // arm at ts 0, hold through ts 3
    sig = 6'h3F;
    step();
    checks++;
    if ({ev_valid, ev_ts, ev_prev, ev_curr} !== {1'b1, 16'd4, 6'h0C, 6'h3F}) begin
      errors++; $display("FAIL post_reset_ts: got v=%b ts=%0d prev=%h curr=%h expected 1/4/0c/3f",
                         ev_valid, ev_ts, ev_prev, ev_curr);
    end
  endtask

  task automatic test_random();
    int ready_pct;
    do_reset(6'h00);
    for (int i = 0; i < 3000; i++) begin
      ready_pct = (i < 1500) ? 30 : 85;
      if ($urandom_range(0, 2) == 0) sig = 6'($urandom);
      ready = ($urandom_range(0, 99) < ready_pct);
      clr   = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 599) != 0);
      step();
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
    rst_n = 1'b1; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ordered_records();
    test_multi_bit();
    test_overflow();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
